// File: rtl/add_sub_control_unit_pkg.sv
// Shared definitions for the add/sub control sequencer.
// Holds the state encoding, default opcodes and instruction-register field positions.
package add_sub_control_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_T0    = 3'd1,
        ST_T1    = 3'd2,
        ST_T2    = 3'd3,
        ST_T3    = 3'd4,
        ST_T4    = 3'd5,
        ST_T5    = 3'd6,
        ST_FAULT = 3'd7
    } state_e;

    localparam logic [4:0] ADD_OPC_DEF = 5'b00011;
    localparam logic [4:0] SUB_OPC_DEF = 5'b00100;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;

    typedef struct packed {
        logic [4:0] opc;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rc;
    } ir_fields_t;

    function automatic ir_fields_t splitIr(input logic [31:0] ir);
        ir_fields_t f;
        f.opc = ir[OPC_HI:OPC_LO];
        f.ra  = ir[RA_HI:RA_LO];
        f.rb  = ir[RB_HI:RB_LO];
        f.rc  = ir[RC_HI:RC_LO];
        return f;
    endfunction

endpackage

// File: rtl/add_sub_control_unit_decoder_4_16.sv
// Enabled 4-to-16 one-hot decoder used for the GPR read and write strobes.
module decoder_4_16 (
    input  logic        en_i,
    input  logic [3:0]  sel_i,
    output logic [15:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/add_sub_control_unit.sv
// Hardwired fetch/execute sequencer for the add/sub datapath.
// Drives datapath strobes per T-state and acts as the memory-read initiator during fetch.
module add_sub_control_unit
    import add_sub_control_unit_pkg::*;
#(
    parameter logic [4:0] ADD_OPC     = ADD_OPC_DEF,
    parameter logic [4:0] SUB_OPC     = SUB_OPC_DEF,
    parameter int         MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] ir_in,
    input  logic        mem_ready,
    output logic        mem_rd,
    output logic        pc_out,
    output logic        zlo_out,
    output logic        mdr_out,
    output logic        mar_in,
    output logic        pc_enable,
    output logic        pc_increment,
    output logic        mdr_enable,
    output logic        mdr_read,
    output logic        ir_enable,
    output logic        y_enable,
    output logic        zlo_enable,
    output logic [4:0]  op_code,
    output logic [15:0] r_enable,
    output logic [15:0] r_out,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic        mem_fault
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] waitCnt_q, waitCnt_d;
    logic       stopPend_q, stopPend_d;
    logic       illegal_q, illegal_d;
    logic       memFault_q, memFault_d;
    logic [4:0] opReg_q, opReg_d;

    ir_fields_t irF;
    logic       rOutEn;
    logic [3:0] rOutSel;
    logic       rEnEn;
    logic       unusedIrBits;

    assign irF          = splitIr(ir_in);
    assign unusedIrBits = ^ir_in[RC_LO-1:0];

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            waitCnt_q  <= '0;
            stopPend_q <= 1'b0;
            illegal_q  <= 1'b0;
            memFault_q <= 1'b0;
            opReg_q    <= '0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            stopPend_q <= stopPend_d;
            illegal_q  <= illegal_d;
            memFault_q <= memFault_d;
            opReg_q    <= opReg_d;
        end
    end

    // Next state plus Moore strobes; T1 read strobes follow mem_ready in the same cycle.
    always_comb begin
        state_d      = state_q;
        waitCnt_d    = waitCnt_q;
        stopPend_d   = stopPend_q | (stop && (state_q != ST_IDLE));
        illegal_d    = 1'b0;
        memFault_d   = memFault_q;
        opReg_d      = opReg_q;
        mem_rd       = 1'b0;
        pc_out       = 1'b0;
        zlo_out      = 1'b0;
        mdr_out      = 1'b0;
        mar_in       = 1'b0;
        pc_enable    = 1'b0;
        pc_increment = 1'b0;
        mdr_enable   = 1'b0;
        mdr_read     = 1'b0;
        ir_enable    = 1'b0;
        y_enable     = 1'b0;
        zlo_enable   = 1'b0;
        op_code      = '0;
        done         = 1'b0;
        rOutEn       = 1'b0;
        rOutSel      = irF.rb;
        rEnEn        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_T0;
                end
            end
            ST_T0: begin
                pc_out       = 1'b1;
                mar_in       = 1'b1;
                pc_enable    = 1'b1;
                pc_increment = 1'b1;
                waitCnt_d    = '0;
                state_d      = ST_T1;
            end
            ST_T1: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    mdr_read   = 1'b1;
                    mdr_enable = 1'b1;
                    waitCnt_d  = '0;
                    state_d    = ST_T2;
                end else if (waitCnt_q == WAIT_LAST) begin
                    waitCnt_d  = '0;
                    memFault_d = 1'b1;
                    state_d    = ST_FAULT;
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                end
            end
            ST_T2: begin
                mdr_out   = 1'b1;
                ir_enable = 1'b1;
                state_d   = ST_T3;
            end
            ST_T3: begin
                if ((irF.opc == ADD_OPC) || (irF.opc == SUB_OPC)) begin
                    rOutEn   = 1'b1;
                    rOutSel  = irF.rb;
                    y_enable = 1'b1;
                    opReg_d  = irF.opc;
                    state_d  = ST_T4;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_T4: begin
                rOutEn     = 1'b1;
                rOutSel    = irF.rc;
                op_code    = opReg_q;
                zlo_enable = 1'b1;
                state_d    = ST_T5;
            end
            ST_T5: begin
                zlo_out = 1'b1;
                rEnEn   = 1'b1;
                done    = 1'b1;
                state_d = (stop || stopPend_q) ? ST_IDLE : ST_T0;
            end
            ST_FAULT: begin
                if (start) begin
                    memFault_d = 1'b0;
                    state_d    = ST_T0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A pending stop is consumed once the sequencer parks in IDLE.
        if (state_d == ST_IDLE) begin
            stopPend_d = 1'b0;
        end
    end

    decoder_4_16 uRoutDec (
        .en_i     (rOutEn),
        .sel_i    (rOutSel),
        .onehot_o (r_out)
    );

    decoder_4_16 uRenDec (
        .en_i     (rEnEn),
        .sel_i    (irF.ra),
        .onehot_o (r_enable)
    );

    assign busy      = (state_q != ST_IDLE) && (state_q != ST_FAULT);
    assign illegal   = illegal_q;
    assign mem_fault = memFault_q;

endmodule

// File: tb/tb_add_sub_control_unit.sv
// Scoreboard bench for add_sub_control_unit: instruction-level model predicts each
// instruction's outcome, a negedge monitor compares whenever done/illegal/fault appears.
module tb_add_sub_control_unit;

    localparam logic [4:0] ADD     = 5'b00011;
    localparam logic [4:0] SUB     = 5'b00100;
    localparam int         TIMEOUT = 15;
    localparam int         NEVER   = 1000;
    localparam int         K_DONE  = 0;
    localparam int         K_ILL   = 1;
    localparam int         K_FAULT = 2;

    typedef struct {
        int          kind;
        int          lat;
        int          memRd;
        int          mdr;
        logic [15:0] rEn;
        logic [15:0] rbMask;
        logic [15:0] rcMask;
        logic [4:0]  op;
        int          issueCyc;
        bit          chained;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr, start, stop, mem_ready;
    logic [31:0] ir_in;
    logic        mem_rd, pc_out, zlo_out, mdr_out, mar_in, pc_enable, pc_increment;
    logic        mdr_enable, mdr_read, ir_enable, y_enable, zlo_enable;
    logic [4:0]  op_code;
    logic [15:0] r_enable, r_out;
    logic        busy, done, illegal, mem_fault;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   memLate = NEVER;
    int   t1Cnt = 0;
    int   issued = 0;
    int   eventCount = 0;
    int   lastEventCyc = 0;
    exp_t expQ[$];

    logic [15:0] obsYRout, obsZRout;
    logic [4:0]  obsOp;
    logic        obsY, prevMemFault;
    int          obsMemRd, obsMdr;

    add_sub_control_unit dut (
        .clk          (clk),
        .clr          (clr),
        .start        (start),
        .stop         (stop),
        .ir_in        (ir_in),
        .mem_ready    (mem_ready),
        .mem_rd       (mem_rd),
        .pc_out       (pc_out),
        .zlo_out      (zlo_out),
        .mdr_out      (mdr_out),
        .mar_in       (mar_in),
        .pc_enable    (pc_enable),
        .pc_increment (pc_increment),
        .mdr_enable   (mdr_enable),
        .mdr_read     (mdr_read),
        .ir_enable    (ir_enable),
        .y_enable     (y_enable),
        .zlo_enable   (zlo_enable),
        .op_code      (op_code),
        .r_enable     (r_enable),
        .r_out        (r_out),
        .busy         (busy),
        .done         (done),
        .illegal      (illegal),
        .mem_fault    (mem_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [52:0] allOut();
        return {mem_rd, pc_out, zlo_out, mdr_out, mar_in, pc_enable, pc_increment,
                mdr_enable, mdr_read, ir_enable, y_enable, zlo_enable, op_code,
                r_enable, r_out, busy, done, illegal, mem_fault};
    endfunction

    function automatic logic [52:0] strobesOnly();
        return {mem_rd, pc_out, zlo_out, mdr_out, mar_in, pc_enable, pc_increment,
                mdr_enable, mdr_read, ir_enable, y_enable, zlo_enable, op_code,
                r_enable, r_out, busy, done, illegal, 1'b0};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Instruction-level model: outcome, latency and handshake counts from the IR and memory delay.
    function automatic exp_t buildExp(input logic [31:0] ir, input int lateCycles);
        exp_t e;
        logic [4:0] opc;
        opc = ir[31:27];
        e = '{default: 0};
        if (lateCycles >= TIMEOUT) begin
            e.kind  = K_FAULT;
            e.lat   = 2 + TIMEOUT;
            e.memRd = TIMEOUT;
            e.mdr   = 0;
        end else if (opc == ADD || opc == SUB) begin
            e.kind   = K_DONE;
            e.lat    = 6 + lateCycles;
            e.memRd  = lateCycles + 1;
            e.mdr    = 1;
            e.rEn    = 16'(1) << ir[26:23];
            e.rbMask = 16'(1) << ir[22:19];
            e.rcMask = 16'(1) << ir[18:15];
            e.op     = opc;
        end else begin
            e.kind  = K_ILL;
            e.lat   = 5 + lateCycles;
            e.memRd = lateCycles + 1;
            e.mdr   = 1;
        end
        return e;
    endfunction

    // Memory responder: raises mem_ready after memLate cycles of a read request.
    always @(posedge clk) begin
        #1;
        if (mem_rd) begin
            mem_ready = (t1Cnt == memLate);
            t1Cnt++;
        end else begin
            mem_ready = 1'b0;
            t1Cnt = 0;
        end
    end

    task automatic evalEvent(input int kind);
        exp_t e;
        int   refCyc;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedEvent actual=%0d required=none", kind);
            return;
        end
        e = expQ.pop_front();
        refCyc = e.chained ? lastEventCyc : e.issueCyc;
        checkOutput("eventKind", 64'(kind), 64'(e.kind));
        if (kind != e.kind) return;
        checkOutput("latency", 64'(cyc - refCyc), 64'(e.lat));
        checkOutput("memRdCycles", 64'(obsMemRd), 64'(e.memRd));
        checkOutput("mdrEnableCycles", 64'(obsMdr), 64'(e.mdr));
        if (kind == K_DONE) begin
            checkOutput("rEnableT5", 64'(r_enable), 64'(e.rEn));
            checkOutput("yEnableSeen", 64'(obsY), 64'd1);
            checkOutput("rOutT3", 64'(obsYRout), 64'(e.rbMask));
            checkOutput("rOutT4", 64'(obsZRout), 64'(e.rcMask));
            checkOutput("opCodeT4", 64'(obsOp), 64'(e.op));
        end else if (kind == K_ILL) begin
            checkOutput("illegalNoYEnable", 64'(obsY), 64'd0);
            checkOutput("illegalBusy", 64'(busy), 64'd0);
        end else begin
            checkOutput("faultStrobes", 64'(strobesOnly()), 64'd0);
        end
    endtask

    always @(negedge clk) begin
        if (clr) begin
            obsY = 1'b0; obsYRout = '0; obsZRout = '0; obsOp = '0;
            obsMemRd = 0; obsMdr = 0; prevMemFault = 1'b0;
        end else begin
            checkOutput("rOutOneHot", 64'($countones(r_out) > 1), 64'd0);
            checkOutput("rEnableOneHot", 64'($countones(r_enable) > 1), 64'd0);
            checkOutput("busDrivers", 64'((32'(pc_out) + 32'(zlo_out) + 32'(mdr_out) + 32'(|r_out)) > 1), 64'd0);
            if (!zlo_enable) checkOutput("opCodeIdle", 64'(op_code), 64'd0);
            if (mem_rd) obsMemRd++;
            if (mdr_enable) obsMdr++;
            if (y_enable) begin obsY = 1'b1; obsYRout = r_out; end
            if (zlo_enable) begin obsZRout = r_out; obsOp = op_code; end
            if (done || illegal || (mem_fault && !prevMemFault)) begin
                evalEvent(done ? K_DONE : (illegal ? K_ILL : K_FAULT));
                eventCount++;
                lastEventCyc = cyc;
                obsY = 1'b0; obsYRout = '0; obsZRout = '0; obsOp = '0;
                obsMemRd = 0; obsMdr = 0;
            end
            prevMemFault = mem_fault;
        end
    end

    task automatic applyStimulus(input logic [31:0] ir, input int lateCycles, input bit chained, input bit startInT2);
        exp_t e;
        e = buildExp(ir, lateCycles);
        e.chained = chained;
        issued++;
        if (chained) begin
            ir_in = ir;
            memLate = lateCycles;
            expQ.push_back(e);
        end else begin
            @(posedge clk); #1;
            ir_in = ir;
            memLate = lateCycles;
            e.issueCyc = cyc;
            expQ.push_back(e);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (startInT2) begin
                @(posedge clk);
                @(posedge clk); #1;
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
    endtask

    task automatic waitEvent(input int budget);
        int n;
        n = 0;
        while (eventCount < issued && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (eventCount < issued) begin
            checks++;
            errors++;
            $display("[TB] FAIL eventTimeout actual=%0d events required=%0d", eventCount, issued);
            eventCount = issued;
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] ir;
        logic [4:0]  opc;
        int          late;
        int          n;

        clr = 1'b1; start = 1'b0; stop = 1'b0; ir_in = '0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; start = 1'b0;
        @(negedge clk);
        checkOutput("resetOutputs", 64'(allOut()), 64'd0);
        checkOutput("clrBeatsStart", 64'(busy), 64'd0);

        // add r1,r4,r4 flowing straight into sub r5,r5,r0 with a slow memory.
        applyStimulus(32'h18A2_0000, 0, 1'b0, 1'b0);
        waitEvent(50);
        #1 stop = 1'b1;
        applyStimulus(32'h22A8_0000, 3, 1'b1, 1'b0);
        waitEvent(50);
        @(negedge clk);
        checkOutput("idleAfterStop", 64'(busy), 64'd0);

        // Ready on the last allowed wait cycle still completes.
        applyStimulus({ADD, 4'd15, 4'd0, 4'd15, 15'h1234}, TIMEOUT - 1, 1'b0, 1'b0);
        waitEvent(60);

        // Memory never answers, then restart from FAULT.
        applyStimulus({SUB, 4'd2, 4'd3, 4'd4, 15'h0}, NEVER, 1'b0, 1'b0);
        waitEvent(60);
        @(negedge clk);
        checkOutput("faultHeld", 64'(mem_fault), 64'd1);
        checkOutput("faultIdleStrobes", 64'(strobesOnly()), 64'd0);
        applyStimulus({ADD, 4'd6, 4'd7, 4'd8, 15'h7FFF}, 1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("faultClearedByStart", 64'(mem_fault), 64'd0);
        waitEvent(50);

        applyStimulus(32'hF800_0000, 2, 1'b0, 1'b0);
        waitEvent(50);
        @(negedge clk);
        checkOutput("illegalPulseWidth", 64'(illegal), 64'd0);

        // Start pulse landing in T2 must not restart or duplicate.
        applyStimulus({ADD, 4'd7, 4'd2, 4'd9, 15'h0}, 0, 1'b0, 1'b1);
        waitEvent(50);
        repeat (2) @(negedge clk);
        checkOutput("noRestartFromT2", 64'(busy), 64'd0);

        // Stop pulsed in T1 only.
        stop = 1'b0;
        applyStimulus({SUB, 4'd5, 4'd5, 4'd5, 15'h0}, 2, 1'b0, 1'b0);
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        waitEvent(50);
        @(negedge clk);
        checkOutput("stopPulseIdle", 64'(busy), 64'd0);

        // Abort a run with clr while in T4.
        @(posedge clk); #1;
        ir_in = {ADD, 4'd3, 4'd1, 4'd2, 15'h0};
        memLate = 0;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!zlo_enable && n < 20);
        checkOutput("reachedT4", 64'(zlo_enable), 64'd1);
        #1 clr = 1'b1;
        @(negedge clk);
        checkOutput("clrAbortOutputs", 64'(allOut()), 64'd0);
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
        checkOutput("idleAfterAbort", 64'(allOut()), 64'd0);

        stop = 1'b1;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: opc = ADD;
                1: opc = SUB;
                2: opc = 5'($urandom);
                default: opc = ADD;
            endcase
            ir = {opc, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)};
            late = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 6));
            applyStimulus(ir, late, 1'b0, 1'b0);
            waitEvent(80);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (5) @(posedge clk);
        checkOutput("scoreboardEmpty", 64'(expQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
